// File: rtl/pixel_pkg.sv
// pixel_pkg: shared types for the pixel row assembler.
// Holds the default pixel width, the pixel type and the per-bank state enum.
package pixel_pkg;

  localparam int PIX_W_DEF = 8;

  typedef logic [PIX_W_DEF-1:0] pixel_t;

  // Lifecycle of one row bank: free, being written, or holding a complete row
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_st_e;

  // A bank blocks the writer only while it holds an unconsumed row
  function automatic logic bank_is_full(input bank_st_e st);
    return st == FULL;
  endfunction

endpackage

// File: rtl/row_bank.sv
// row_bank: one image row of SIZE pixels.
// Single-column write port, full-row parallel read. Contents are not reset;
// validity is tracked by the owner through the bank state.
module row_bank
  import pixel_pkg::*;
#(
  parameter int SIZE  = 100,
  parameter int PIX_W = PIX_W_DEF,
  localparam int CW   = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [CW-1:0]    col_i,
  input  logic [PIX_W-1:0] din_i,
  output logic [PIX_W-1:0] row_o [SIZE]
);

  logic [PIX_W-1:0] mem_q [SIZE];

  // Column write: only the addressed element captures the incoming pixel
  always_ff @(posedge clk) begin
    for (int c = 0; c < SIZE; c++) begin
      if (we_i && (col_i == CW'(c))) begin
        mem_q[c] <= din_i;
      end
    end
  end

  assign row_o = mem_q;

endmodule

// File: rtl/pixel_row_assembler.sv
// pixel_row_assembler: packs a raster pixel stream into full rows.
// Two row banks form a ping-pong pair: one fills from the stream while the
// other waits for the consumer. Rows are delivered in completion order.
// Optional feature macro: PIXEL_ROW_SOF_RESYNC_EN (sof forces column 0, row 0).
module pixel_row_assembler
  import pixel_pkg::*;
#(
  parameter int SIZE  = 100,
  parameter int PIX_W = PIX_W_DEF,
  localparam int CW   = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic             sof,
  output logic [PIX_W-1:0] row_out [SIZE],
  output logic             row_valid,
  input  logic             row_ready,
  output logic [CW-1:0]    row_idx,
  output logic             frame_done
);

  // Bank bookkeeping. fill_q selects the bank being written, rd_q the oldest
  // full bank. Because banks complete and drain alternately, toggling each
  // pointer on its own event keeps delivery in completion order.
  bank_st_e          st_q  [2];
  bank_st_e          st_d  [2];
  logic [CW-1:0]     tag_q [2];   // frame row number captured at completion
  logic [CW-1:0]     tag_d [2];
  logic              fill_q, fill_d;
  logic              rd_q,   rd_d;
  logic [CW-1:0]     col_q,  col_d;
  logic [CW-1:0]     row_q,  row_d;   // row number of the row being filled

  logic              pix_fire;
  logic              row_fire;
  logic              resync;
  logic [CW-1:0]     wr_col;
  logic [CW-1:0]     row_eff;
  logic              row_done;

  logic [PIX_W-1:0]  bank0_row [SIZE];
  logic [PIX_W-1:0]  bank1_row [SIZE];

  assign pix_ready = rst_n && !bank_is_full(st_q[fill_q]);
  assign row_valid = bank_is_full(st_q[rd_q]);
  assign pix_fire  = pix_valid && pix_ready;
  assign row_fire  = row_valid && row_ready;

`ifdef PIXEL_ROW_SOF_RESYNC_EN
  // A sof pixel restarts the frame unless it already lands at column 0, row 0
  assign resync = pix_fire && sof && ((col_q != '0) || (row_q != '0));
`else
  logic unused_sof;
  assign unused_sof = sof;
  assign resync     = 1'b0;
`endif

  assign wr_col   = resync ? '0 : col_q;
  assign row_eff  = resync ? '0 : row_q;
  assign row_done = pix_fire && (wr_col == CW'(SIZE - 1));

  row_bank #(.SIZE(SIZE), .PIX_W(PIX_W)) u_bank0 (
    .clk   (clk),
    .we_i  (pix_fire && !fill_q),
    .col_i (wr_col),
    .din_i (pix_in),
    .row_o (bank0_row)
  );

  row_bank #(.SIZE(SIZE), .PIX_W(PIX_W)) u_bank1 (
    .clk   (clk),
    .we_i  (pix_fire && fill_q),
    .col_i (wr_col),
    .din_i (pix_in),
    .row_o (bank1_row)
  );

  // Next-state: drain first so a bank freed this cycle can be refilled at once
  always_comb begin
    st_d   = st_q;
    tag_d  = tag_q;
    fill_d = fill_q;
    rd_d   = rd_q;
    col_d  = col_q;
    row_d  = row_q;

    if (row_fire) begin
      st_d[rd_q] = EMPTY;
      rd_d       = ~rd_q;
    end

    if (pix_fire) begin
      if (row_done) begin
        st_d[fill_q]  = FULL;
        tag_d[fill_q] = row_eff;
        col_d         = '0;
        row_d         = (row_eff == CW'(SIZE - 1)) ? '0 : row_eff + 1'b1;
        fill_d        = ~fill_q;
      end else begin
        col_d = wr_col + 1'b1;
        row_d = row_eff;
      end
    end

    // Claim the fill bank as soon as it is free
    if (st_d[fill_d] == EMPTY) begin
      st_d[fill_d] = FILLING;
    end
  end

  // State registers; bank contents stay untouched by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q[0]  <= EMPTY;
      st_q[1]  <= EMPTY;
      tag_q[0] <= '0;
      tag_q[1] <= '0;
      fill_q   <= 1'b0;
      rd_q     <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
    end else begin
      st_q   <= st_d;
      tag_q  <= tag_d;
      fill_q <= fill_d;
      rd_q   <= rd_d;
      col_q  <= col_d;
      row_q  <= row_d;
    end
  end

  // Output mux: present the oldest full bank, zeros when nothing is valid
  always_comb begin
    for (int c = 0; c < SIZE; c++) begin
      row_out[c] = '0;
      if (row_valid) begin
        row_out[c] = rd_q ? bank1_row[c] : bank0_row[c];
      end
    end
  end

  assign row_idx    = row_valid ? tag_q[rd_q] : '0;
  assign frame_done = row_fire && (tag_q[rd_q] == CW'(SIZE - 1));

endmodule

// File: tb/tb_pixel_row_assembler.sv
// Directed bench for pixel_row_assembler with SIZE = 4.
module tb_pixel_row_assembler;

  localparam int SIZE = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pix_in = '0;
  logic       pix_valid = 1'b0;
  logic       pix_ready;
  logic       sof = 1'b0;
  logic [7:0] row_out [SIZE];
  logic       row_valid;
  logic       row_ready = 1'b0;
  logic [1:0] row_idx;
  logic       frame_done;

  int checks = 0;
  int failures = 0;
  int stalls = 0;
  int fd_cnt = 0;
  logic [1:0]  fd_idx = '0;
  logic [31:0] q_rows [$];
  logic [1:0]  q_idx  [$];

  always #5 clk = ~clk;

  pixel_row_assembler #(.SIZE(SIZE), .PIX_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .sof        (sof),
    .row_out    (row_out),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .row_idx    (row_idx),
    .frame_done (frame_done)
  );

  function automatic logic [31:0] row_word();
    return {row_out[0], row_out[1], row_out[2], row_out[3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Record every row transfer, frame_done pulse and refused pixel
  always @(negedge clk) begin
    if (rst_n) begin
      if (row_valid && row_ready) begin
        q_rows.push_back(row_word());
        q_idx.push_back(row_idx);
      end
      if (frame_done) begin
        fd_cnt++;
        fd_idx = row_idx;
      end
      if (pix_valid && !pix_ready) stalls++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [7:0] px, input logic s);
    bit done;
    done = 1'b0;
    pix_in = px; sof = s; pix_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      done = pix_ready;
      cyc();
    end
    pix_valid = 1'b0; sof = 1'b0;
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [7:0] first, input int n);
    for (int k = 0; k < n; k++) send_one(first + 8'(k), 1'b0);
  endtask

  task automatic do_reset(input logic rr);
    pix_valid = 1'b0; sof = 1'b0; row_ready = rr; rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    q_rows.delete(); q_idx.delete();
    stalls = 0; fd_cnt = 0;
  endtask

  task automatic expect_row(input string tag, input logic [31:0] w, input logic [1:0] idx);
    if (q_rows.size() == 0) begin
      chk({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_data"}, q_rows.pop_front(), w);
      chk({tag, "_idx"}, 32'(q_idx.pop_front()), 32'(idx));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    rst_n = 1'b0; row_ready = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    chk("rst_pix_ready", 32'(pix_ready), 32'd0);
    chk("rst_row_valid", 32'(row_valid), 32'd0);
    chk("rst_row_idx", 32'(row_idx), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_row_out", row_word(), 32'd0);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(pix_ready), 32'd1);
    cyc();

    // First row: valid only in the cycle after the 4th accept
    send(8'h10, 3);
    @(negedge clk);
    chk("t1_not_yet", 32'(row_valid), 32'd0);
    cyc();
    send(8'h13, 1);
    @(negedge clk);
    chk("t1_valid", 32'(row_valid), 32'd1);
    chk("t1_row", row_word(), 32'h10111213);
    chk("t1_idx", 32'(row_idx), 32'd0);
    cyc();
    @(negedge clk);
    chk("t1_consumed", 32'(row_valid), 32'd0);
    chk("t1_zero_out", row_word(), 32'd0);
    cyc();
    expect_row("t1_q", 32'h10111213, 2'd0);

    // Full frame plus one row, continuous
    do_reset(1'b1);
    send(8'h00, 20);
    repeat (3) cyc();
    chk("t2_stalls", 32'(stalls), 32'd0);
    expect_row("t2_r0", 32'h00010203, 2'd0);
    expect_row("t2_r1", 32'h04050607, 2'd1);
    expect_row("t2_r2", 32'h08090a0b, 2'd2);
    expect_row("t2_r3", 32'h0c0d0e0f, 2'd3);
    expect_row("t2_r4", 32'h10111213, 2'd0);
    chk("t2_fd_cnt", 32'(fd_cnt), 32'd1);
    chk("t2_fd_idx", 32'(fd_idx), 32'd3);

    // Backpressure: both banks fill, 0x08 is held
    do_reset(1'b0);
    send(8'h00, 8);
    chk("t3_no_early_stall", 32'(stalls), 32'd0);
    pix_in = 8'h08; pix_valid = 1'b1;
    @(negedge clk);
    chk("t3_ready_low", 32'(pix_ready), 32'd0);
    chk("t3_head_row", row_word(), 32'h00010203);
    cyc();
    @(negedge clk);
    chk("t3_ready_low2", 32'(pix_ready), 32'd0);
    cyc();
    row_ready = 1'b1;
    send(8'h08, 4);
    repeat (3) cyc();
    expect_row("t3_r0", 32'h00010203, 2'd0);
    expect_row("t3_r1", 32'h04050607, 2'd1);
    expect_row("t3_r2", 32'h08090a0b, 2'd2);

    // Reset mid-frame discards held rows
    do_reset(1'b0);
    send(8'h50, 6);
    @(negedge clk);
    chk("t4_before", 32'(row_valid), 32'd1);
    cyc();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t4_rst_ready", 32'(pix_ready), 32'd0);
    cyc();
    @(negedge clk);
    chk("t4_rst_valid", 32'(row_valid), 32'd0);
    chk("t4_rst_idx", 32'(row_idx), 32'd0);
    chk("t4_rst_out", row_word(), 32'd0);
    cyc();
    rst_n = 1'b1; row_ready = 1'b1;
    q_rows.delete(); q_idx.delete();
    send(8'hA0, 4);
    repeat (2) cyc();
    expect_row("t4_fresh", 32'ha0a1a2a3, 2'd0);
    chk("t4_no_stale", 32'(q_rows.size()), 32'd0);

    // sof on the 3rd pixel of row 1
    do_reset(1'b1);
    send(8'h20, 4);
    send(8'h24, 2);
    send_one(8'h26, 1'b1);
    send(8'h27, 5);
    repeat (3) cyc();
    expect_row("t5_r0", 32'h20212223, 2'd0);
`ifdef PIXEL_ROW_SOF_RESYNC_EN
    expect_row("t5_resync", 32'h26272829, 2'd0);
`else
    expect_row("t5_r1", 32'h24252627, 2'd1);
    expect_row("t5_r2", 32'h28292a2b, 2'd2);
`endif
    chk("t5_leftover", 32'(q_rows.size()), 32'd0);

    // Row completion and row transfer on the same edge, no bubble after
    do_reset(1'b0);
    send(8'h30, 7);
    row_ready = 1'b1;
    stalls = 0;
    send(8'h37, 5);
    repeat (3) cyc();
    chk("t6_stalls", 32'(stalls), 32'd0);
    expect_row("t6_r0", 32'h30313233, 2'd0);
    expect_row("t6_r1", 32'h34353637, 2'd1);
    expect_row("t6_r2", 32'h38393a3b, 2'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
